mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive BUSY cycles one owner may hold the mux (legal range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  4  request lines; req[i] is requester i, level-sensitive.
REQ-005 Port: W  input  4  data inputs of the shared 4:1 mux; W[i] belongs to requester i.
REQ-006 Port: gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 Port: S  output  2  mux select (S[1]=S1, S[0]=S0), registered, index of the current owner.
REQ-008 Port: y  output  1  registered mux output.
REQ-009 Port: busy  output  1  registered; high while in state BUSY.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-011 In IDLE with req != 0, the block SHALL pick the first requester with req set, searching round-robin from (last+1) mod 4, where last is the most recently granted index.
REQ-012 On that edge: state goes to BUSY, gnt = one-hot(winner), S = winner, last = winner, hold counter = 0.
REQ-013 In IDLE with req == 0: state, S and last unchanged; gnt = 0.
REQ-014 In BUSY, y SHALL equal W[S] sampled at each rising edge (one-cycle latency from W to y).
REQ-015 In IDLE, y SHALL be 0.
REQ-016 In BUSY, the hold counter SHALL increment by 1 per cycle. It saturates at MAX_HOLD-1 and does not wrap.
REQ-017 BUSY SHALL release to IDLE on the edge where req[S] is sampled low. On release: gnt = 0, busy = 0, y = 0.
REQ-018 BUSY SHALL release to IDLE on the edge where the hold counter equals MAX_HOLD-1 (timeout), regardless of req[S].
REQ-019 Each release SHALL give exactly one IDLE cycle before any new grant (minimum one-cycle gap).
REQ-020 Requests from non-owners during BUSY SHALL be ignored. Their req[i] changes do not disturb gnt, S or y.
REQ-021 Simultaneous requests SHALL resolve strictly by the round-robin order of REQ-011; no index has fixed priority.
REQ-022 A requester still asserting after a timeout SHALL only be re-granted if no other requester is asserting in the following IDLE cycle.
REQ-023 gnt SHALL never have more than one bit set. S SHALL hold its value whenever gnt is 0.

Reset
REQ-024 When rst_n is low, the block SHALL immediately (asynchronously) force state = IDLE, gnt = 0, S = 0, y = 0, busy = 0, hold counter = 0, last = 3. With last = 3, the first search starts at index 0.
REQ-025 Reset asserted mid-BUSY SHALL abort the grant with no further output activity.
REQ-026 After rst_n deasserts, arbitration SHALL resume on the first rising edge.

Configuration
REQ-027 Macro MUX_ARB_TIMEOUT_EN defined: the timeout of REQ-016/REQ-018 and the hold counter SHALL be compiled in.
REQ-028 Macro MUX_ARB_TIMEOUT_EN undefined: no hold counter exists. BUSY releases only per REQ-017, and MAX_HOLD is ignored.

Verification
REQ-029 Reset/idle: rst_n=0 then 1, req=0000 for 5 cycles -> gnt=0000, S=00, y=0, busy=0 throughout.
REQ-030 Single requester: req=0100, W=0100 -> next edge gnt=0100, S=10, busy=1; following edge y=1. Drop req[2] -> next edge gnt=0000, y=0.
REQ-031 Round-robin: req=1111 held, each owner drops its req for one cycle after 2 BUSY cycles, then re-raises -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-032 Timeout (macro defined, MAX_HOLD=8): req=0011 held -> requester 0 is BUSY for exactly 8 cycles, then 1 IDLE cycle, then gnt=0010. Macro undefined: requester 0 is held indefinitely.
REQ-033 Async reset mid-grant: while gnt=1000, pulse rst_n low between edges -> gnt, S, y, busy go to 0 without waiting for a clock edge. After release with req=1000, gnt=1000 one edge later.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner arbiter for a shared 4:1 mux; optional hold timeout via MUX_ARB_TIMEOUT_EN
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] W,
  output logic [3:0] gnt,
  output logic [1:0] S,
  output logic       y,
  output logic       busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_n;
  logic [3:0] gnt_n;
  logic [1:0] s_n;
  logic       y_n;
  logic       busy_n;
  logic [1:0] last, last_n;
  logic [1:0] winner;
  logic       timeout;

  // Round-robin search starting one past the most recent owner; wraps back to last itself.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found  = 1'b0;
    idx    = last;
    winner = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold;

  // Count cycles of the current ownership; cleared while idle, saturating at the last permitted cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (state == IDLE) begin
      hold <= '0;
    end else if (hold != HOLD_LAST) begin
      hold <= hold + 8'd1;
    end
  end

  assign timeout = (state == BUSY) && (hold == HOLD_LAST);
`else
  // Without the timeout MAX_HOLD has no effect; it is kept so both builds share one interface.
  logic unused_max_hold;
  assign unused_max_hold = ^8'(MAX_HOLD);
  assign timeout = 1'b0;
`endif

  // Next-state and next registered outputs; every target holds unless a branch overrides it.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    s_n     = S;
    y_n     = y;
    busy_n  = busy;
    last_n  = last;
    case (state)
      IDLE: begin
        gnt_n  = 4'b0000;
        y_n    = 1'b0;
        busy_n = 1'b0;
        if (|req) begin
          state_n = BUSY;
          gnt_n   = 4'b0001 << winner;
          s_n     = winner;
          last_n  = winner;
          busy_n  = 1'b1;
        end
      end
      BUSY: begin
        // Release forces the mandatory idle gap: the grant only happens from IDLE.
        if (!req[S] || timeout) begin
          state_n = IDLE;
          gnt_n   = 4'b0000;
          y_n     = 1'b0;
          busy_n  = 1'b0;
        end else begin
          y_n = W[S];
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        y_n     = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      S     <= 2'd0;
      y     <= 1'b0;
      busy  <= 1'b0;
      last  <= 2'd3;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      S     <= s_n;
      y     <= y_n;
      busy  <= busy_n;
      last  <= last_n;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] W;
  logic [3:0] gnt;
  logic [1:0] S;
  logic       y;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  mux_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .W    (W),
    .gnt  (gnt),
    .S    (S),
    .y    (y),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clean restart so last returns to 3.
  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Expected vectors are {gnt, S, y, busy}.
  task automatic test_reset();
    logic [7:0] exp;
    rst_n = 1'b0;
    req   = 4'b0000;
    W     = 4'b0000;
    tick();
    tick();
    exp = 8'b0000_00_0_0;
    n_checks++;
    if ({gnt, S, y, busy} !== exp) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", {gnt, S, y, busy}, exp);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({gnt, S, y, busy} !== exp) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %b expected %b", i, {gnt, S, y, busy}, exp);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] exp [5];
    exp[0] = 8'b0100_10_0_1;
    exp[1] = 8'b0100_10_1_1;
    exp[2] = 8'b0100_10_0_1;
    exp[3] = 8'b0000_10_0_0;
    exp[4] = 8'b0000_10_0_0;
    req = 4'b0100;
    W   = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) W = 4'b0000;
      if (i == 3) req = 4'b0000;
      tick();
      n_checks++;
      if ({gnt, S, y, busy} !== exp[i]) begin
        n_fail++;
        $display("FAIL single[%0d]: got %b expected %b", i, {gnt, S, y, busy}, exp[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] wv;
    logic [1:0] order [5];
    logic [7:0] exp;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    reset_pulse();
    wv  = 4'b1010;
    W   = wv;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      exp = {4'b0001 << order[g], order[g], 1'b0, 1'b1};
      n_checks++;
      if ({gnt, S, y, busy} !== exp) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", g, {gnt, S, y, busy}, exp);
      end
      tick();
      exp = {4'b0001 << order[g], order[g], wv[order[g]], 1'b1};
      n_checks++;
      if ({gnt, S, y, busy} !== exp) begin
        n_fail++;
        $display("FAIL rr_busy[%0d]: got %b expected %b", g, {gnt, S, y, busy}, exp);
      end
      req[order[g]] = 1'b0;
      tick();
      exp = {4'b0000, order[g], 1'b0, 1'b0};
      n_checks++;
      if ({gnt, S, y, busy} !== exp) begin
        n_fail++;
        $display("FAIL rr_release[%0d]: got %b expected %b", g, {gnt, S, y, busy}, exp);
      end
      req[order[g]] = 1'b1;
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_non_owner();
    logic [3:0] pat [4];
    logic [7:0] exp;
    pat[0] = 4'b1111; pat[1] = 4'b1011; pat[2] = 4'b0110; pat[3] = 4'b0010;
    reset_pulse();
    W   = 4'b0010;
    req = 4'b0010;
    tick();
    exp = 8'b0010_01_0_1;
    n_checks++;
    if ({gnt, S, y, busy} !== exp) begin
      n_fail++;
      $display("FAIL nonowner_grant: got %b expected %b", {gnt, S, y, busy}, exp);
    end
    exp = 8'b0010_01_1_1;
    for (int i = 0; i < 4; i++) begin
      req = pat[i];
      tick();
      n_checks++;
      if ({gnt, S, y, busy} !== exp) begin
        n_fail++;
        $display("FAIL nonowner_hold[%0d]: got %b expected %b", i, {gnt, S, y, busy}, exp);
      end
    end
    req = 4'b1101;
    tick();
    exp = 8'b0000_01_0_0;
    n_checks++;
    if ({gnt, S, y, busy} !== exp) begin
      n_fail++;
      $display("FAIL nonowner_release: got %b expected %b", {gnt, S, y, busy}, exp);
    end
    tick();
    exp = 8'b0100_10_0_1;
    n_checks++;
    if ({gnt, S, y, busy} !== exp) begin
      n_fail++;
      $display("FAIL nonowner_next_rr: got %b expected %b", {gnt, S, y, busy}, exp);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    reset_pulse();
    W   = 4'b0000;
    req = 4'b0011;
    tick();
    exp = 8'b0001_00_0_1;
    n_checks++;
    if ({gnt, S, y, busy} !== exp) begin
      n_fail++;
      $display("FAIL timeout_grant: got %b expected %b", {gnt, S, y, busy}, exp);
    end
`ifdef MUX_ARB_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if ({gnt, S, y, busy} !== exp) begin
        n_fail++;
        $display("FAIL timeout_hold[%0d]: got %b expected %b", i, {gnt, S, y, busy}, exp);
      end
    end
    tick();
    exp = 8'b0000_00_0_0;
    n_checks++;
    if ({gnt, S, y, busy} !== exp) begin
      n_fail++;
      $display("FAIL timeout_release: got %b expected %b", {gnt, S, y, busy}, exp);
    end
    tick();
    exp = 8'b0010_01_0_1;
    n_checks++;
    if ({gnt, S, y, busy} !== exp) begin
      n_fail++;
      $display("FAIL timeout_next: got %b expected %b", {gnt, S, y, busy}, exp);
    end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if ({gnt, S, y, busy} !== exp) begin
        n_fail++;
        $display("FAIL no_timeout_hold[%0d]: got %b expected %b", i, {gnt, S, y, busy}, exp);
      end
    end
`endif
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    reset_pulse();
    req = 4'b1000;
    W   = 4'b1000;
    tick();
    exp = 8'b1000_11_0_1;
    n_checks++;
    if ({gnt, S, y, busy} !== exp) begin
      n_fail++;
      $display("FAIL async_grant: got %b expected %b", {gnt, S, y, busy}, exp);
    end
    tick();
    exp = 8'b1000_11_1_1;
    n_checks++;
    if ({gnt, S, y, busy} !== exp) begin
      n_fail++;
      $display("FAIL async_busy: got %b expected %b", {gnt, S, y, busy}, exp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp = 8'b0000_00_0_0;
    n_checks++;
    if ({gnt, S, y, busy} !== exp) begin
      n_fail++;
      $display("FAIL async_clear: got %b expected %b", {gnt, S, y, busy}, exp);
    end
    #1;
    rst_n = 1'b1;
    tick();
    exp = 8'b1000_11_0_1;
    n_checks++;
    if ({gnt, S, y, busy} !== exp) begin
      n_fail++;
      $display("FAIL async_regrant: got %b expected %b", {gnt, S, y, busy}, exp);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    W     = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_non_owner();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
